// File: rtl/pea_firing_scheduler.sv
// pea_firing_scheduler: autonomous CFDF firing sequencer for the PEA actor.
// Optional WAIT_FC watchdog (timeout_cycles port, TIMEOUT_W) enabled by defining PEA_SCHED_WATCHDOG_EN.
module pea_firing_scheduler #(
   parameter int unsigned COUNT_W = 16
`ifdef PEA_SCHED_WATCHDOG_EN
   ,
   parameter int unsigned TIMEOUT_W = 16
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   input  logic                 enable,
   input  logic                 FC,
   input  logic [1:0]           next_mode_in,
   input  logic                 clear_err,
`ifdef PEA_SCHED_WATCHDOG_EN
   input  logic [TIMEOUT_W-1:0] timeout_cycles,
`endif
   output logic [1:0]           next_instr,
   output logic                 invoke,
   output logic                 busy,
   output logic [COUNT_W-1:0]   fire_count,
   output logic                 error
);

   localparam logic [1:0] MODE_SETUP   = 2'b00;
   localparam logic [1:0] MODE_INVALID = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_CHECK,
      S_INVOKE,
      S_WAIT_FC,
      S_ERROR
   } state_e;

   state_e               state_q, state_d;
   logic                 run_q, run_d;
   logic                 arm_q, arm_d;
   logic [1:0]           next_instr_q, next_instr_d;
   logic [COUNT_W-1:0]   fire_count_q, fire_count_d;
   logic                 invoke_q, invoke_d;
   logic                 busy_q, busy_d;
   logic                 error_q, error_d;
   logic                 wd_hit;
   logic                 accept;

`ifdef PEA_SCHED_WATCHDOG_EN
   logic [TIMEOUT_W-1:0] wd_cnt_q, wd_cnt_d;
`endif

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         run_q        <= 1'b0;
         arm_q        <= 1'b0;
         next_instr_q <= MODE_SETUP;
         fire_count_q <= '0;
         invoke_q     <= 1'b0;
         busy_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         run_q        <= run_d;
         arm_q        <= arm_d;
         next_instr_q <= next_instr_d;
         fire_count_q <= fire_count_d;
         invoke_q     <= invoke_d;
         busy_q       <= busy_d;
         error_q      <= error_d;
      end
   end

`ifdef PEA_SCHED_WATCHDOG_EN
   // Cycles spent in the current WAIT_FC, counted from the blanking cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt_q <= '0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
      end
   end

   always_comb begin
      wd_cnt_d = wd_cnt_q;
      if (state_q == S_INVOKE) begin
         wd_cnt_d = '0;
      end else if (state_q == S_WAIT_FC) begin
         wd_cnt_d = wd_cnt_q + TIMEOUT_W'(1);
      end
      // wd_cnt_q + 1 is the ordinal of the current WAIT_FC cycle
      wd_hit = (timeout_cycles != '0) &&
               ((wd_cnt_q + TIMEOUT_W'(1)) == timeout_cycles);
   end
`else
   always_comb begin
      wd_hit = 1'b0;
   end
`endif

   // FC only counts after the blanking cycle, which masks a stale completion
   always_comb begin
      accept = arm_q && FC;
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      run_d        = run;
      arm_d        = (state_q == S_WAIT_FC);
      next_instr_d = next_instr_q;
      fire_count_d = fire_count_q;
      error_d      = error_q;

      unique case (state_q)
         S_IDLE: begin
            if (run_q) begin
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            state_d = S_CHECK;
         end
         S_CHECK: begin
            if (!run_q) begin
               state_d = S_IDLE;
            end else if (enable) begin
               state_d = S_INVOKE;
            end
         end
         S_INVOKE: begin
            state_d = S_WAIT_FC;
         end
         S_WAIT_FC: begin
            if (accept) begin
               if (next_mode_in == MODE_INVALID) begin
                  state_d = S_ERROR;
                  error_d = 1'b1;
               end else begin
                  state_d      = S_SETTLE;
                  next_instr_d = next_mode_in;
                  if (fire_count_q != '1) begin
                     fire_count_d = fire_count_q + COUNT_W'(1);
                  end
               end
            end else if (wd_hit) begin
               state_d = S_ERROR;
               error_d = 1'b1;
            end
         end
         S_ERROR: begin
            if (clear_err) begin
               state_d      = S_IDLE;
               error_d      = 1'b0;
               next_instr_d = MODE_SETUP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      invoke_d = (state_d == S_INVOKE);
      busy_d   = (state_d != S_IDLE) && (state_d != S_ERROR);
   end

   assign next_instr = next_instr_q;
   assign invoke     = invoke_q;
   assign busy       = busy_q;
   assign fire_count = fire_count_q;
   assign error      = error_q;

endmodule

// File: tb/tb_pea_firing_scheduler.sv
// Self-checking bench for pea_firing_scheduler; expectations come from the
// documented edge timing (invoke 4 edges after run is driven, accept at max(3,k+1)).
module tb_pea_firing_scheduler;

   localparam int unsigned CW = 3;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk, rst, run, enable, FC, clear_err;
   logic [1:0]    next_mode_in, next_instr;
   logic          invoke, busy, err;
   logic [CW-1:0] fire_count;
`ifdef PEA_SCHED_WATCHDOG_EN
   logic [15:0]   timeout_cycles;
`endif

   int         errors, checks, cyc;
   logic [1:0] exp_mode;
   int         exp_cnt;

   pea_firing_scheduler #(.COUNT_W(CW)) dut (
      .clk(clk),
      .rst(rst),
      .run(run),
      .enable(enable),
      .FC(FC),
      .next_mode_in(next_mode_in),
      .clear_err(clear_err),
`ifdef PEA_SCHED_WATCHDOG_EN
      .timeout_cycles(timeout_cycles),
`endif
      .next_instr(next_instr),
      .invoke(invoke),
      .busy(busy),
      .fire_count(fire_count),
      .error(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1; run = 1'b0; enable = 1'b0; FC = 1'b0;
      clear_err = 1'b0; next_mode_in = 2'b00;
`ifdef PEA_SCHED_WATCHDOG_EN
      timeout_cycles = 16'd0;
`endif
      tick(); tick();
      rst = 1'b0;
      exp_mode = 2'b00;
      exp_cnt  = 0;
   endtask

   // One firing: FC driven k cycles after invoke is seen; acceptance expected at max(3,k+1)
   task automatic fire_one(input logic [1:0] mode, input int k, input int exp_inv,
                           input bit hold, input int drop_at, output int acc);
      bit seen;
      int t0, j, want_cnt;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (invoke === 1'b1) seen = 1'b1;
         else tick();
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL invoke_wait: no invoke within budget at cycle %0d", cyc);
         acc = cyc;
         return;
      end
      t0 = cyc;
      if (exp_inv >= 0) begin
         checks++;
         if (t0 !== exp_inv) begin
            errors++;
            $display("FAIL invoke_time: got cycle %0d want %0d", t0, exp_inv);
         end
      end
      j = (k + 1 > 3) ? k + 1 : 3;
      if (k == 0) begin FC = 1'b1; next_mode_in = mode; end
      for (int i = 1; i <= j; i++) begin
         tick();
         if (i == 1) begin
            checks++;
            if (invoke !== 1'b0) begin
               errors++;
               $display("FAIL invoke_width: got %b want 0 one cycle after invoke", invoke);
            end
         end
         if (i < j) begin
            checks++;
            if ({next_instr, fire_count, busy} !== {exp_mode, CW'(exp_cnt), 1'b1}) begin
               errors++;
               $display("FAIL wait_hold: got mode=%b cnt=%0d busy=%b want mode=%b cnt=%0d busy=1 (wait cycle %0d)",
                        next_instr, fire_count, busy, exp_mode, exp_cnt, i);
            end
         end else begin
            want_cnt = (exp_cnt < MAXC) ? exp_cnt + 1 : MAXC;
            checks++;
            if ({next_instr, fire_count, busy} !== {mode, CW'(want_cnt), 1'b1}) begin
               errors++;
               $display("FAIL accept: got mode=%b cnt=%0d busy=%b want mode=%b cnt=%0d busy=1",
                        next_instr, fire_count, busy, mode, want_cnt);
            end
            exp_mode = mode;
            exp_cnt  = want_cnt;
            if (!hold) FC = 1'b0;
         end
         if (i == k) begin FC = 1'b1; next_mode_in = mode; end
         if (i == drop_at) run = 1'b0;
      end
      acc = cyc;
   endtask

   task automatic test_reset();
      int c, acc;
      do_reset();
      checks++;
      if ({next_instr, invoke, busy, fire_count, err} !== '0) begin
         errors++;
         $display("FAIL reset_values: got %b want all zero", {next_instr, invoke, busy, fire_count, err});
      end
      run = 1'b1; enable = 1'b1; c = cyc;
      repeat (4) tick();
      checks++;
      if (invoke !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_invoke: got %b want 1 at cycle %0d", invoke, c + 4);
      end
      tick();
      FC = 1'b1; next_mode_in = 2'b10;
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if ({next_instr, invoke, busy, fire_count, err} !== '0) begin
         errors++;
         $display("FAIL reset_mid_wait: got %b want all zero", {next_instr, invoke, busy, fire_count, err});
      end
      run = 1'b0; FC = 1'b0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if ({invoke, busy, fire_count} !== '0) begin
            errors++;
            $display("FAIL reset_quiet: got invoke=%b busy=%b cnt=%0d want 0 0 0", invoke, busy, fire_count);
         end
      end
      run = 1'b1; c = cyc;
      fire_one(2'b01, 3, c + 4, 1'b0, -1, acc);
      run = 1'b0;
   endtask

   task automatic test_normal();
      int c, acc;
      logic [1:0] m;
      do_reset();
      run = 1'b1; enable = 1'b1; c = cyc;
      fire_one(2'b01, 3, c + 4, 1'b0, -1, acc);
      fire_one(2'b00, 3, acc + 2, 1'b0, -1, acc);
      fire_one(2'b10, 3, acc + 2, 1'b0, -1, acc);
      checks++;
      if (fire_count !== CW'(3)) begin
         errors++;
         $display("FAIL normal_count: got %0d want 3", fire_count);
      end
      // six more random firings drive the counter into saturation
      for (int n = 0; n < 6; n++) begin
         m = 2'($urandom_range(0, 2));
         fire_one(m, int'($urandom_range(0, 5)), acc + 2, 1'b0, -1, acc);
      end
      checks++;
      if (fire_count !== CW'(MAXC)) begin
         errors++;
         $display("FAIL saturate: got %0d want %0d", fire_count, MAXC);
      end
      run = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (invoke !== 1'b0) begin
            errors++;
            $display("FAIL normal_stop: got invoke=%b want 0", invoke);
         end
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL normal_idle: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_enable_gating();
      int acc;
      do_reset();
      run = 1'b1;
      repeat (3) tick();
      for (int i = 0; i < 6; i++) begin
         checks++;
         if ({invoke, busy} !== 2'b01) begin
            errors++;
            $display("FAIL gate_hold: got invoke=%b busy=%b want 0 1", invoke, busy);
         end
         tick();
      end
      enable = 1'b1;
      fire_one(2'b10, 2, cyc + 1, 1'b0, -1, acc);
      run = 1'b0;
   endtask

   task automatic test_stale_fc();
      int c, acc;
      logic [1:0] m;
      do_reset();
      FC = 1'b1; run = 1'b1; enable = 1'b1; c = cyc;
      m = 2'($urandom_range(0, 2));
      fire_one(m, 0, c + 4, 1'b1, -1, acc);
      for (int n = 0; n < 2; n++) begin
         m = 2'($urandom_range(0, 2));
         fire_one(m, 0, acc + 2, 1'b1, -1, acc);
      end
      FC = 1'b0; run = 1'b0;
   endtask

   task automatic test_invalid_mode();
      int c, acc;
      do_reset();
      run = 1'b1; enable = 1'b1; c = cyc;
      fire_one(2'b01, 2, c + 4, 1'b0, -1, acc);
      tick(); tick();
      checks++;
      if (invoke !== 1'b1) begin
         errors++;
         $display("FAIL invalid_invoke: got %b want 1", invoke);
      end
      tick();
      FC = 1'b1; next_mode_in = 2'b11;
      tick();
      checks++;
      if ({err, busy} !== 2'b01) begin
         errors++;
         $display("FAIL invalid_blank: got err=%b busy=%b want 0 1", err, busy);
      end
      tick();
      checks++;
      if ({err, busy, next_instr, fire_count} !== {1'b1, 1'b0, exp_mode, CW'(exp_cnt)}) begin
         errors++;
         $display("FAIL invalid_accept: got err=%b busy=%b mode=%b cnt=%0d want 1 0 %b %0d",
                  err, busy, next_instr, fire_count, exp_mode, exp_cnt);
      end
      FC = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if ({invoke, err, busy} !== 3'b010) begin
            errors++;
            $display("FAIL error_hold: got invoke=%b err=%b busy=%b want 0 1 0", invoke, err, busy);
         end
      end
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      exp_mode = 2'b00;
      checks++;
      if ({err, next_instr, busy} !== {1'b0, exp_mode, 1'b0}) begin
         errors++;
         $display("FAIL clear_err: got err=%b mode=%b busy=%b want 0 00 0", err, next_instr, busy);
      end
      run = 1'b0;
   endtask

   task automatic test_run_drop();
      int c, acc;
      do_reset();
      run = 1'b1; enable = 1'b1; c = cyc;
      fire_one(2'b10, 3, c + 4, 1'b0, 1, acc);
      tick();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL drop_check: got busy=%b want 1", busy);
      end
      tick();
      checks++;
      if ({busy, invoke, fire_count} !== {1'b0, 1'b0, CW'(1)}) begin
         errors++;
         $display("FAIL drop_idle: got busy=%b invoke=%b cnt=%0d want 0 0 1", busy, invoke, fire_count);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (invoke !== 1'b0) begin
            errors++;
            $display("FAIL drop_quiet: got invoke=%b want 0", invoke);
         end
      end
   endtask

`ifdef PEA_SCHED_WATCHDOG_EN
   task automatic test_watchdog();
      do_reset();
      timeout_cycles = 16'd8;
      run = 1'b1; enable = 1'b1;
      repeat (4) tick();
      checks++;
      if (invoke !== 1'b1) begin
         errors++;
         $display("FAIL wd_invoke: got %b want 1", invoke);
      end
      for (int i = 1; i <= 9; i++) begin
         tick();
         checks++;
         if (i <= 8 && {err, busy} !== 2'b01) begin
            errors++;
            $display("FAIL wd_wait: got err=%b busy=%b want 0 1 (wait cycle %0d)", err, busy, i);
         end else if (i == 9 && {err, busy} !== 2'b10) begin
            errors++;
            $display("FAIL wd_fire: got err=%b busy=%b want 1 0", err, busy);
         end
      end
      run = 1'b0;
   endtask
`endif

   initial begin
      errors = 0; checks = 0; cyc = 0;
      test_reset();
      test_normal();
      test_enable_gating();
      test_stale_fc();
      test_invalid_mode();
      test_run_drop();
`ifdef PEA_SCHED_WATCHDOG_EN
      test_watchdog();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pea_firing_scheduler.md
# pea_firing_scheduler

Autonomous firing sequencer for the PEA actor. Replaces bench-driven hand-sequencing of `invoke`/`next_instr` with a state machine. It presents the current CFDF mode to `PEA_top_module_1` and `PEA_enable`, pulses `invoke` only when `enable` is true, and waits for `FC`. It then adopts the actor's reported next mode and repeats while `run` is high. It sits between the system controller and the PEA top/enable pair.

## Interface
Parameters:
- `COUNT_W`, default 16: width of the firing counter.
- `TIMEOUT_W`, default 16: width of the watchdog limit. Used only with `PEA_SCHED_WATCHDOG_EN`.

Ports:
- `clk`  in  1  : single clock, rising edge.
- `rst`  in  1  : asynchronous, active-high reset.
- `run`  in  1  : level; scheduler issues firings while high.
- `enable`  in  1  : from `PEA_enable`; valid one cycle after `next_instr` settles.
- `FC`  in  1  : firing complete from `PEA_top_module_1`, level.
- `next_mode_in`  in  2  : actor's next mode; sampled only when `FC` is accepted.
- `clear_err`  in  1  : one-cycle pulse; leaves the ERROR state.
- `timeout_cycles`  in  `TIMEOUT_W`  : watchdog limit; 0 disables the watchdog. Present only with the macro.
- `next_instr`  out  2  : current mode (00 SETUP_INSTR, 01 INSTR, 10 OUTPUT).
- `invoke`  out  1  : registered, exactly one cycle per firing.
- `busy`  out  1  : high in every state except IDLE and ERROR.
- `fire_count`  out  `COUNT_W`  : completed firings; saturates at all-ones.
- `error`  out  1  : sticky; set by an invalid mode or by a watchdog timeout.

## Operation
States:
- **IDLE**
  - Stays in IDLE while `run`=0.
  - Goes to SETTLE when `run`=1.
- **SETTLE**
  - Lasts one cycle, so the combinational `enable` path can follow `next_instr`.
  - Always goes to CHECK.
- **CHECK**
  - Goes to IDLE if `run`=0. The `run` check has priority over `enable`.
  - Otherwise goes to INVOKE if `enable`=1.
  - Otherwise stays in CHECK.
- **INVOKE**
  - `invoke`=1 for this one cycle only.
  - Always goes to WAIT_FC.
- **WAIT_FC**
  - The first cycle is a blanking cycle: `FC` is ignored, to mask a stale completion from the previous firing.
  - From the second cycle on, `FC`=1 accepts the completion, with these actions on the same clock edge:
    - `next_mode_in` is loaded into `next_instr`.
    - `fire_count` is incremented, saturating.
    - The next state is SETTLE.
  - If `next_mode_in`=11 at acceptance, the next state is ERROR instead. `next_instr` and `fire_count` are left unchanged and `error` is set.
  - A firing already issued is never aborted. `run` falling during WAIT_FC takes effect in the following CHECK.
- **ERROR**
  - `invoke` is never asserted.
  - `clear_err`=1 goes to IDLE, clears `error` and sets `next_instr`=00.

Other rules:
- `next_instr` changes only on an FC acceptance or on `clear_err`.
- Reset values: `next_instr`=00, `invoke`=0, `busy`=0, `fire_count`=0, `error`=0, state IDLE.
- `rst` takes effect immediately in any state, including mid-firing. No completion is recorded for a firing interrupted by reset.

## Timing
- `run` is first sampled high at edge 0.
  - Edge 1 enters SETTLE.
  - Edge 2 enters CHECK.
  - With `enable`=1, edge 3 enters INVOKE, and `invoke` is high between edges 3 and 4.
- Minimum time from `invoke` to acceptance: FC high on the second WAIT_FC cycle, so acceptance is at the edge 2 cycles after `invoke` falls.
- From acceptance to the next `invoke`: 2 edges (SETTLE, CHECK), then INVOKE on the 3rd edge.
- Minimum period between successive firings: 5 cycles.
- `enable` going high while in CHECK: `invoke` is asserted from the next edge.

## Configuration
Macro `PEA_SCHED_WATCHDOG_EN`:
- **Defined:**
  - The `timeout_cycles` port and a `TIMEOUT_W`-bit counter are present.
  - The counter clears on entry to WAIT_FC and increments on each WAIT_FC cycle, blanking cycle included.
  - When the counter equals `timeout_cycles` (nonzero) and FC is not accepted on that cycle, the next state is ERROR and `error`=1.
- **Undefined:**
  - Neither the port nor the counter exists, and WAIT_FC waits indefinitely.
  - `error` is set only by an invalid mode.

## Test plan
- **Reset:** assert `rst` mid-WAIT_FC → all outputs return to their reset values at once, and `invoke` stays 0 until `run` is set again.
- **Normal sequence:**
  - Stimulus: `run`=1, `enable`=1, with FC rising 3 cycles after each `invoke` and modes 01, 00, 10 in turn.
  - Required: one `invoke` per firing, `next_instr` steps 00→01→00→10, and `fire_count`=3.
- **Enable gating:** `enable`=0 for 6 cycles while in CHECK → no `invoke`; `enable` raised → `invoke` on the next edge, lasting exactly 1 cycle.
- **Stale FC:** hold FC=1 continuously → each firing completes on its second WAIT_FC cycle, never on the first.
- **Invalid mode:**
  - `next_mode_in`=11 at FC → `error`=1, `busy`=0, `next_instr` unchanged, `fire_count` unchanged, no further `invoke`.
  - Then `clear_err` → `error`=0 and `next_instr`=00.
- **Watchdog and run drop:**
  - Watchdog: with the macro defined, `timeout_cycles`=8 and FC held low → ERROR entered at the edge after the 8th WAIT_FC cycle.
  - Run drop: clear `run` during WAIT_FC → the firing completes, `fire_count` increments, then IDLE with `busy`=0.
